// File: rtl/dilithium_core_arbiter_if.sv
// Bundle of the requester-side and core-side handshake/stream signals
// around the shared Dilithium core.
// Handshake rule for every valid/ready pair: a word moves on a clk edge
// where valid and ready are both 1; valid must hold with stable data until
// that edge, and ready may change freely.
interface dilithium_core_arbiter_if;
  // requester side
  logic [1:0]  req_start;
  logic [3:0]  req_mode;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_i;
  logic [63:0] req_data_i;
  logic [1:0]  req_valid_o;
  logic [1:0]  req_ready_o;
  logic [31:0] req_data_o;
  logic [1:0]  req_done;
  logic [1:0]  req_err;
  // core side
  logic        core_start;
  logic [1:0]  core_mode;
  logic        core_valid_i;
  logic        core_ready_i;
  logic [31:0] core_data_i;
  logic        core_valid_o;
  logic        core_ready_o;
  logic [31:0] core_data_o;
  logic        core_done;

  // arbiter view
  modport slave (
    input  req_start, req_mode, req_valid_i, req_data_i, req_ready_o,
    input  core_ready_i, core_valid_o, core_data_o, core_done,
    output req_ready_i, req_valid_o, req_data_o, req_done, req_err,
    output core_start, core_mode, core_valid_i, core_data_i, core_ready_o
  );

  // environment view (requesters plus core)
  modport master (
    output req_start, req_mode, req_valid_i, req_data_i, req_ready_o,
    output core_ready_i, core_valid_o, core_data_o, core_done,
    input  req_ready_i, req_valid_o, req_data_o, req_done, req_err,
    input  core_start, core_mode, core_valid_i, core_data_i, core_ready_o
  );
endinterface

// File: rtl/dilithium_core_arbiter.sv
// Round-robin arbiter sharing one Dilithium core between two requesters.
// Latches start requests, launches the core, steers the streams to the
// owner, returns done, and records the cycle count of each job.
module dilithium_core_arbiter #(
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  dilithium_core_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 owner,
  output logic [CNT_W-1:0]     last_cycles,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [1:0]       pending_q, pending_d;
  logic [1:0][1:0]  mode_q, mode_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] last_cycles_q, last_cycles_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       accept;
  logic             owner_active;

  // Request latching, arbitration and job-timing next-state logic
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    mode_d        = mode_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    last_cycles_d = last_cycles_q;
    err_d         = 2'b00;
    accept        = 2'b00;
    owner_active  = (state_q == S_LAUNCH) || (state_q == S_BUSY);

    for (int i = 0; i < 2; i++) begin
      accept[i] = bus.req_start[i] && (bus.req_mode[2*i +: 2] != 2'd3) &&
                  !pending_q[i] && !(owner_active && (owner_q == 1'(i)));
      err_d[i]  = bus.req_start[i] && !accept[i];
      if (accept[i]) begin
        pending_d[i] = 1'b1;
        mode_d[i]    = bus.req_mode[2*i +: 2];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q != 2'b00) begin
          // both waiting: the one not served last time wins
          owner_d = (pending_q == 2'b11) ? ~last_grant_q : pending_q[1];
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        pending_d[owner_q] = 1'b0;
        cnt_d              = CNT_ONE;
        state_d            = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (bus.core_done) begin
          // job length counts LAUNCH through the core_done cycle inclusive
          last_cycles_d = cnt_d;
          state_d       = S_DONE;
        end
      end
      default: begin
        last_grant_d = owner_q;
        state_d      = S_IDLE;
      end
    endcase
  end

  // Registered state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      pending_q     <= 2'b00;
      mode_q        <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      last_cycles_q <= '0;
      err_q         <= 2'b00;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      mode_q        <= mode_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      last_cycles_q <= last_cycles_d;
      err_q         <= err_d;
    end
  end

  // Core control pulses and stream steering to the current owner
  always_comb begin
    bus.core_start   = (state_q == S_LAUNCH);
    bus.core_mode    = (state_q == S_LAUNCH) ? mode_q[owner_q] : 2'd0;
    bus.core_valid_i = 1'b0;
    bus.core_data_i  = 32'd0;
    bus.core_ready_o = 1'b0;
    bus.req_ready_i  = 2'b00;
    bus.req_valid_o  = 2'b00;
    bus.req_data_o   = 32'd0;
    bus.req_done     = 2'b00;
    bus.req_err      = err_q;
    if (state_q == S_BUSY) begin
      bus.core_valid_i         = bus.req_valid_i[owner_q];
      bus.core_data_i          = owner_q ? bus.req_data_i[63:32] : bus.req_data_i[31:0];
      bus.req_ready_i[owner_q] = bus.core_ready_i;
      bus.req_valid_o[owner_q] = bus.core_valid_o;
      bus.core_ready_o         = bus.req_ready_o[owner_q];
      bus.req_data_o           = bus.core_data_o;
    end
    if (state_q == S_DONE) begin
      bus.req_done[owner_q] = 1'b1;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign owner       = owner_q;
  assign last_cycles = last_cycles_q;
  assign dbg_state   = state_q;

endmodule
